// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: reads 24-bit words over req/ack and issues opcode/operands with valid/ready.
// Optional FETCH_HALT_OPCODE_EN: opcode 8'hFF parks the block in HALT instead of issuing.
module instr_fetch #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [23:0]       mem_rdata,
    output logic [7:0]        opcode,
    output logic [7:0]        operand1,
    output logic [7:0]        operand2,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       instr_count,
    output logic              busy,
    output logic              halted,
    output logic [1:0]        state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    // Handshake: a transfer happens on every rising edge where issue_valid and
    // issue_ready are both high; memory reads complete on the edge with mem_req and mem_ack high.
    logic [1:0] state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pc          <= '0;
            opcode      <= 8'h00;
            operand1    <= 8'h00;
            operand2    <= 8'h00;
            instr_count <= 16'h0000;
        end else if (stop) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE, HALT: begin
                    if (start) begin
                        pc          <= start_addr;
                        instr_count <= 16'h0000;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        opcode   <= mem_rdata[23:16];
                        operand1 <= mem_rdata[15:8];
                        operand2 <= mem_rdata[7:0];
`ifdef FETCH_HALT_OPCODE_EN
                        state_q  <= (mem_rdata[23:16] == 8'hFF) ? HALT : ISSUE;
`else
                        state_q  <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
                    if (issue_ready) begin
                        pc <= pc + 1'b1;
                        if (instr_count != 16'hFFFF) begin
                            instr_count <= instr_count + 16'd1;
                        end
                        state_q <= REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // All outputs decode from registers only, so no input reaches an output combinationally.
    assign state       = state_q;
    assign mem_req     = (state_q == REQ);
    assign mem_addr    = pc;
    assign issue_valid = (state_q == ISSUE);
    assign busy        = (state_q == REQ) || (state_q == ISSUE);
`ifdef FETCH_HALT_OPCODE_EN
    assign halted      = (state_q == HALT);
`else
    assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized runs checked against an address-sequence model.
// Honours FETCH_HALT_OPCODE_EN to select the expected behaviour of opcode 8'hFF.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset, start, stop, mem_ack, issue_ready;
    logic [7:0]  start_addr;
    logic [23:0] mem_rdata;
    logic        mem_req, issue_valid, busy, halted;
    logic [7:0]  mem_addr, opcode, operand1, operand2, pc;
    logic [15:0] instr_count;
    logic [1:0]  state;

    int tests_run = 0;
    int tests_failed = 0;

    logic [23:0] mem [256];
    bit          mem_en = 1'b1;
    int          ack_wait_max = 0;
    logic [23:0] exp_q [$];

    instr_fetch #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .start_addr(start_addr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .opcode(opcode), .operand1(operand1), .operand2(operand2),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .pc(pc),
        .instr_count(instr_count), .busy(busy), .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Memory responder plus one clock; outputs are sampled 1ns after the edge.
    task automatic tick();
        if (mem_req) mem_ack = mem_en && ($urandom_range(0, ack_wait_max) == 0);
        else         mem_ack = ($urandom_range(0, 3) == 0);
        mem_rdata = (mem_req && mem_ack) ? mem[mem_addr] : 24'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic run_random(input logic [7:0] sa, input int n);
        logic [7:0]  exp_pc;
        logic [15:0] exp_cnt;
        logic [23:0] held;
        bit          hs, was_held;
        int          cyc;
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(mem[8'(sa + i)]);
        exp_pc = sa;
        exp_cnt = 16'd0;
        was_held = 1'b0;
        held = 24'h0;
        start = 1'b1; start_addr = sa;
        tick();
        start = 1'b0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 3000) begin
            issue_ready = 1'($urandom_range(0, 1));
            if (was_held) begin
                check_eq("held_valid", {31'd0, issue_valid}, 32'd1);
                check_eq("held_word", {opcode, operand1, operand2}, held);
            end
            if (mem_req) check_eq("rnd_mem_addr", mem_addr, exp_pc);
            hs = issue_valid && issue_ready;
            was_held = issue_valid && !issue_ready;
            held = {opcode, operand1, operand2};
            if (hs) begin
                check_eq("rnd_word", {opcode, operand1, operand2}, exp_q.pop_front());
                exp_pc = exp_pc + 8'd1;
                if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            end
            tick();
            if (hs) begin
                check_eq("rnd_pc", pc, exp_pc);
                check_eq("rnd_count", instr_count, exp_cnt);
                check_eq("rnd_req_after_hs", {31'd0, mem_req}, 32'd1);
            end
            cyc++;
        end
        check_eq("rnd_timeout_left", exp_q.size(), 0);
        stop_pulse();
        check_eq("rnd_stop_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [23:0] saved;
        for (int i = 0; i < 256; i++) mem[i] = {8'($urandom_range(0, 254)), 16'($urandom)};
        reset = 1'b1; start = 1'b0; stop = 1'b0; start_addr = 8'h00;
        issue_ready = 1'b0; mem_ack = 1'b0; mem_rdata = 24'h0;
        tick(); tick();
        reset = 1'b0;
        check_eq("rst_pc", pc, 0);
        check_eq("rst_count", instr_count, 0);
        check_eq("rst_word", {opcode, operand1, operand2}, 0);
        check_eq("rst_flags", {mem_req, issue_valid, busy, halted}, 0);

        // Basic zero-wait fetch
        mem[8'h10] = 24'h010503;
        ack_wait_max = 0; issue_ready = 1'b1;
        start = 1'b1; start_addr = 8'h10;
        tick();
        start = 1'b0;
        check_eq("basic_req", {31'd0, mem_req}, 1);
        check_eq("basic_addr", mem_addr, 8'h10);
        tick();
        check_eq("basic_valid", {31'd0, issue_valid}, 1);
        check_eq("basic_word", {opcode, operand1, operand2}, 24'h010503);
        tick();
        check_eq("basic_pc", pc, 8'h11);
        check_eq("basic_count", instr_count, 1);
        check_eq("basic_req2", {31'd0, mem_req}, 1);

        // Back-pressure
        issue_ready = 1'b0;
        tick();
        check_eq("bp_word0", {opcode, operand1, operand2}, mem[8'h11]);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_valid", {31'd0, issue_valid}, 1);
            check_eq("bp_req", {31'd0, mem_req}, 0);
            check_eq("bp_word", {opcode, operand1, operand2}, mem[8'h11]);
        end
        issue_ready = 1'b1;
        tick();
        check_eq("bp_release_req", {31'd0, mem_req}, 1);
        check_eq("bp_release_pc", pc, 8'h12);
        check_eq("bp_release_count", instr_count, 2);

        // Stop and start together while in REQ: stop wins
        mem_en = 1'b0;
        stop = 1'b1; start = 1'b1; start_addr = 8'h40;
        tick();
        stop = 1'b0; start = 1'b0;
        check_eq("stop_flags", {mem_req, issue_valid, busy}, 0);
        check_eq("stop_state", state, 0);
        check_eq("stop_pc", pc, 8'h12);
        check_eq("stop_count", instr_count, 2);
        tick();
        check_eq("stop_idle_req", {31'd0, mem_req}, 0);
        mem_en = 1'b1;

        // Wrap-around
        start = 1'b1; start_addr = 8'hFF;
        tick();
        start = 1'b0;
        check_eq("wrap_addr0", mem_addr, 8'hFF);
        tick(); tick();
        check_eq("wrap_pc", pc, 8'h00);
        check_eq("wrap_addr", mem_addr, 8'h00);
        check_eq("wrap_count", instr_count, 1);
        stop_pulse();

        // Halt opcode on the third word
        saved = mem[8'h22];
        mem[8'h22] = 24'hFF1234;
        start = 1'b1; start_addr = 8'h20;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
`ifdef FETCH_HALT_OPCODE_EN
        check_eq("halt_halted", {31'd0, halted}, 1);
        check_eq("halt_flags", {issue_valid, busy, mem_req}, 0);
        check_eq("halt_word", {opcode, operand1, operand2}, 24'hFF1234);
        check_eq("halt_pc", pc, 8'h22);
        check_eq("halt_count", instr_count, 2);
        tick();
        check_eq("halt_stay", {halted, issue_valid}, 2'b10);
        start = 1'b1; start_addr = 8'h30;
        tick();
        start = 1'b0;
        check_eq("halt_restart_req", {31'd0, mem_req}, 1);
        check_eq("halt_restart_pc", pc, 8'h30);
        check_eq("halt_restart_count", instr_count, 0);
        check_eq("halt_restart_halted", {31'd0, halted}, 0);
`else
        check_eq("ff_valid", {31'd0, issue_valid}, 1);
        check_eq("ff_word", {opcode, operand1, operand2}, 24'hFF1234);
        check_eq("ff_halted", {31'd0, halted}, 0);
        tick();
        check_eq("ff_count", instr_count, 3);
        check_eq("ff_pc", pc, 8'h23);
`endif
        stop_pulse();
        mem[8'h22] = saved;

        // Reset in the middle of ISSUE
        issue_ready = 1'b0;
        start = 1'b1; start_addr = 8'h50;
        tick();
        start = 1'b0;
        tick();
        check_eq("mid_valid", {31'd0, issue_valid}, 1);
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check_eq("mid_rst_pc", pc, 0);
        check_eq("mid_rst_count", instr_count, 0);
        check_eq("mid_rst_word", {opcode, operand1, operand2}, 0);
        check_eq("mid_rst_flags", {mem_req, issue_valid, busy, halted}, 0);
        check_eq("mid_rst_state", state, 0);
        tick();
        check_eq("mid_rst_req", {31'd0, mem_req}, 0);

        // Randomized runs with wait states and random back-pressure
        ack_wait_max = 3;
        for (int r = 0; r < 4; r++) run_random(8'($urandom), 24);
        ack_wait_max = 0;
        run_random(8'hF8, 16);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
